// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-outstanding memory port.
// Latency: grant is combinational in IDLE; response 3 cycles after grant with an immediate ack, 1 cycle for an illegal address.
// Backpressure: requesters hold their request until gnt; fetch is forced after STARVE_MAX consecutive data wins over it.
module mem_port_arbiter #(
    parameter int                ADDR_W     = 20,
    parameter int                DATA_W     = 8,
    parameter logic [ADDR_W-1:0] MEM_LIMIT  = 20'hFF000,
    parameter int                TIMEOUT    = 16,
    parameter int                STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mv,
    output logic              mc
);

    localparam int SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int TC_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [SC_W-1:0] STARVE_TOP = SC_W'(STARVE_MAX);
    localparam logic [TC_W-1:0] WAIT_LAST  = TC_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    logic [SC_W-1:0]   r_starve;
    logic [TC_W-1:0]   r_wait_cnt;
    logic              r_owner_d;
    logic              r_we;
    logic              r_f_rvalid, r_f_err, r_d_rvalid, r_d_err;
    logic [DATA_W-1:0] r_f_rdata, r_d_rdata;
    logic              r_mem_req, r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mv, r_mc;

    logic              w_idle;
    logic              w_any;
    logic              w_pick_d;
    logic [ADDR_W-1:0] w_addr;
    logic              w_illegal;

    // Grants are only offered in IDLE and are held off while reset is asserted.
    assign w_idle    = (r_state == S_IDLE) && rst_n;
    assign w_any     = f_req || d_req;
    assign w_pick_d  = d_req && (!f_req || (r_starve != STARVE_TOP));
    assign w_addr    = w_pick_d ? d_addr : f_addr;
    assign w_illegal = (w_addr >= MEM_LIMIT);

    assign f_gnt     = w_idle && f_req && !w_pick_d;
    assign d_gnt     = w_idle && w_pick_d;
    assign f_rvalid  = r_f_rvalid;
    assign f_rdata   = r_f_rdata;
    assign f_err     = r_f_err;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign d_err     = r_d_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mv        = r_mv;
    assign mc        = r_mc;

    // Transaction FSM; every output is a single-cycle registered pulse set on the state transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_starve    <= '0;
            r_wait_cnt  <= '0;
            r_owner_d   <= 1'b0;
            r_we        <= 1'b0;
            r_f_rvalid  <= 1'b0;
            r_f_err     <= 1'b0;
            r_f_rdata   <= '0;
            r_d_rvalid  <= 1'b0;
            r_d_err     <= 1'b0;
            r_d_rdata   <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mv        <= 1'b0;
            r_mc        <= 1'b0;
        end else begin
            r_f_rvalid  <= 1'b0;
            r_f_err     <= 1'b0;
            r_f_rdata   <= '0;
            r_d_rvalid  <= 1'b0;
            r_d_err     <= 1'b0;
            r_d_rdata   <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mv        <= 1'b0;
            r_mc        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner_d <= w_pick_d;
                        r_we      <= w_pick_d && d_we;
                        if (w_pick_d && f_req) begin
                            if (r_starve != STARVE_TOP) r_starve <= r_starve + 1'b1;
                        end else begin
                            r_starve <= '0;
                        end
                        if (w_illegal) begin
                            // Illegal address: answer straight away, memory is never touched.
                            r_state    <= S_RESP;
                            r_mv       <= 1'b1;
                            r_d_rvalid <= w_pick_d;
                            r_d_err    <= w_pick_d;
                            r_f_rvalid <= !w_pick_d;
                            r_f_err    <= !w_pick_d;
                        end else begin
                            r_state     <= S_ISSUE;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= w_pick_d && d_we;
                            r_mem_addr  <= w_addr;
                            r_mem_wdata <= w_pick_d ? d_wdata : '0;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state    <= S_WAIT;
                    r_wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        r_state    <= S_RESP;
                        r_d_rvalid <= r_owner_d;
                        r_f_rvalid <= !r_owner_d;
                        if (!r_we) begin
                            if (r_owner_d) r_d_rdata <= mem_rdata;
                            else           r_f_rdata <= mem_rdata;
                        end
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_state    <= S_RESP;
                        r_mc       <= 1'b1;
                        r_d_rvalid <= r_owner_d;
                        r_d_err    <= r_owner_d;
                        r_f_rvalid <= !r_owner_d;
                        r_f_err    <= !r_owner_d;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, memory address width (2**20 bytes).
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have parameter MEM_LIMIT, default 20'hFF000, first illegal address; addr >= MEM_LIMIT is a violation.
REQ-004 SHALL have parameter TIMEOUT, default 16, max WAIT cycles before error.
REQ-005 SHALL have parameter STARVE_MAX, default 4, consecutive data wins over a pending fetch before fetch is forced.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 f_req  in  1  fetch request (read-only); f_addr  in  ADDR_W  fetch address.
REQ-009 f_gnt  out  1  fetch accepted pulse; f_rvalid  out  1  fetch response pulse; f_rdata  out  DATA_W; f_err  out  1.
REQ-010 d_req  in  1  data request; d_we  in  1  1=store; d_addr  in  ADDR_W; d_wdata  in  DATA_W.
REQ-011 d_gnt  out  1; d_rvalid  out  1; d_rdata  out  DATA_W; d_err  out  1 -- same meaning as fetch port.
REQ-012 mem_req  out  1; mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_ack  in  1; mem_rdata  in  DATA_W.
REQ-013 mv  out  1  memory-violation pulse; mc  out  1  timeout pulse (feed status-register MV/MC bits).

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; one transaction outstanding at a time.
REQ-015 Requester holds req/addr/we/wdata stable until its gnt; gnt is a 1-cycle pulse asserted only in IDLE.
REQ-016 IDLE: if any req, grant one (combinational gnt), latch owner/addr/we/wdata; legal addr -> ISSUE, illegal -> RESP with error.
REQ-017 Arbitration: d_req alone -> data; f_req alone -> fetch; both -> data unless starve_cnt == STARVE_MAX, then fetch.
REQ-018 starve_cnt SHALL increment (saturating) on each data grant while f_req high, clear on any fetch grant or data grant with f_req low.
REQ-019 ISSUE: mem_req=1 for exactly one cycle with latched mem_we/mem_addr/mem_wdata; -> WAIT.
REQ-020 WAIT: mem_req=0; mem_ack sampled only here; on ack latch mem_rdata -> RESP ok; after TIMEOUT cycles without ack -> RESP with error, mc=1 for one cycle on RESP entry.
REQ-021 RESP: owner's rvalid=1 for one cycle, rdata = latched data (0 for stores and errors), err per outcome; -> IDLE.
REQ-022 Violation: no mem_req ever issued; mv=1 during the RESP cycle; err=1.
REQ-023 Non-owner rvalid/err/gnt SHALL remain 0; mem_* outputs 0 outside ISSUE.
REQ-024 Minimum latency: gnt at cycle N, mem_req N+1, ack earliest N+2, rvalid N+3; violation rvalid at N+1.
REQ-025 New request may be granted the cycle after RESP (back-to-back period 4 cycles min).
REQ-026 mem_ack outside WAIT (late/stray) SHALL be ignored.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, starve_cnt 0, all outputs 0 (gnt, rvalid, err, rdata, mem_*, mv, mc), regardless of state.
REQ-028 After rst_n release, first grant possible on the first rising edge with req high; no response is produced for a transaction aborted by reset.

Verification
REQ-029 f_req, f_addr=20'h00100, mem_ack 1 cycle after mem_req, mem_rdata=8'hA5 -> f_gnt N, mem_req N+1 (we=0), f_rvalid N+3 with f_rdata=8'hA5, f_err=0.
REQ-030 d_req, d_we=1, d_addr=20'h00200, d_wdata=8'h3C -> mem_req with mem_we=1, mem_wdata=8'h3C; d_rvalid with d_rdata=0, d_err=0.
REQ-031 f_req and d_req held continuously -> grant order D,D,D,D,F,D,D,D,D,F...; no fetch starves.
REQ-032 d_addr=20'hFF000 -> d_gnt, no mem_req, next cycle d_rvalid=1, d_err=1, mv=1.
REQ-033 mem_ack never asserted -> after 16 WAIT cycles owner rvalid=1, err=1, mc=1, rdata=0; stray mem_ack afterwards ignored.
REQ-034 rst_n pulsed low during WAIT -> all outputs 0 asynchronously; subsequent mem_ack produces no rvalid; next request served normally.
